// File: rtl/pixel_addr_gen.sv
// Frame-buffer column/row/linear address generator for the VGA read path.
// Horizontal prescaler per memory pixel, vertical line repeat per memory row.
module pixel_addr_gen #(
  parameter int PRESCALE = 20,
  parameter int H_PIXELS = 128,
  parameter int V_PIXELS = 96,
  parameter int V_REPEAT = 5,
  parameter int HW = $clog2(H_PIXELS),
  parameter int VW = $clog2(V_PIXELS),
  parameter int AW = $clog2(H_PIXELS * V_PIXELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_active,
  input  logic          line_end,
  input  logic          frame_start,
  output logic [HW-1:0] hpixel,
  output logic [VW-1:0] vpixel,
  output logic [AW-1:0] addr,
  output logic          pixel_tick,
  output logic          frame_done
);

  // Degenerate PRESCALE/V_REPEAT of 1 still get a 1-bit counter that stays 0.
  localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (V_REPEAT > 1) ? $clog2(V_REPEAT) : 1;

  localparam logic [SW-1:0] SUB_LAST = SW'(PRESCALE - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(V_REPEAT - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_PIXELS - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_PIXELS - 1);

  logic [SW-1:0] sub_cnt;
  logic [RW-1:0] line_rep;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_cnt    <= '0;
      hpixel     <= '0;
      vpixel     <= '0;
      line_rep   <= '0;
      pixel_tick <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pixel_tick <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start) begin
        sub_cnt  <= '0;
        hpixel   <= '0;
        vpixel   <= '0;
        line_rep <= '0;
      end else if (line_end) begin
        // Any pixel advance due this cycle is dropped; the next line starts at column 0.
        sub_cnt <= '0;
        hpixel  <= '0;
        if (line_rep == REP_LAST) begin
          line_rep <= '0;
          if (vpixel == V_LAST) begin
            vpixel     <= '0;
            frame_done <= 1'b1;
          end else begin
            vpixel <= vpixel + 1'b1;
          end
        end else begin
          line_rep <= line_rep + 1'b1;
        end
      end else if (line_active) begin
        if (sub_cnt == SUB_LAST) begin
          sub_cnt    <= '0;
          pixel_tick <= 1'b1;
          hpixel     <= (hpixel == H_LAST) ? '0 : hpixel + 1'b1;
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end else begin
        sub_cnt <= '0;
      end
    end
  end

  assign addr = AW'(vpixel) * AW'(H_PIXELS) + AW'(hpixel);

endmodule

// File: tb/tb_pixel_addr_gen.sv
// Directed bench for pixel_addr_gen: default build plus a PRESCALE=1, H_PIXELS=4 build.
module tb_pixel_addr_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic line_active = 1'b0, line_end = 1'b0, frame_start = 1'b0;
  logic [6:0]  hpixel;
  logic [6:0]  vpixel;
  logic [13:0] addr;
  logic        pixel_tick, frame_done;

  logic line_active_b = 1'b0, line_end_b = 1'b0, frame_start_b = 1'b0;
  logic [1:0] hpixel_b;
  logic [6:0] vpixel_b;
  logic [8:0] addr_b;
  logic       pixel_tick_b, frame_done_b;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pixel_addr_gen dut (
    .clk(clk), .reset(reset), .line_active(line_active), .line_end(line_end),
    .frame_start(frame_start), .hpixel(hpixel), .vpixel(vpixel), .addr(addr),
    .pixel_tick(pixel_tick), .frame_done(frame_done)
  );

  pixel_addr_gen #(.PRESCALE(1), .H_PIXELS(4)) dut_b (
    .clk(clk), .reset(reset), .line_active(line_active_b), .line_end(line_end_b),
    .frame_start(frame_start_b), .hpixel(hpixel_b), .vpixel(vpixel_b), .addr(addr_b),
    .pixel_tick(pixel_tick_b), .frame_done(frame_done_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line_end();
    line_end = 1'b1;
    step();
    line_end = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_hpixel", int'(hpixel), 0);
    chk("rst_vpixel", int'(vpixel), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_tick", int'(pixel_tick), 0);
    chk("rst_done", int'(frame_done), 0);
    step();
    step();

    // 1 + 2: prescaled horizontal counting and wrap
    reset = 1'b1;
    line_active = 1'b1;
    for (int k = 1; k <= 2560; k++) begin
      step();
      if (k == 19) begin
        chk("t1_h_clk19", int'(hpixel), 0);
        chk("t1_tick_clk19", int'(pixel_tick), 0);
      end
      if (k == 20) begin
        chk("t1_h_clk20", int'(hpixel), 1);
        chk("t1_tick_clk20", int'(pixel_tick), 1);
      end
      if (k == 21) chk("t1_tick_clk21", int'(pixel_tick), 0);
      if (k == 40) begin
        chk("t1_h_clk40", int'(hpixel), 2);
        chk("t1_tick_clk40", int'(pixel_tick), 1);
      end
      if (k == 1300) chk("t2_addr_clk1300", int'(addr), 65);
      if (k == 2540) chk("t2_h_clk2540", int'(hpixel), 127);
      if (k == 2559) chk("t2_tick_clk2559", int'(pixel_tick), 0);
      if (k == 2560) begin
        chk("t2_h_wrap", int'(hpixel), 0);
        chk("t2_tick_wrap", int'(pixel_tick), 1);
        chk("t2_v_stay", int'(vpixel), 0);
        chk("t2_addr_wrap", int'(addr), 0);
      end
    end

    // 3: vertical repeat and frame wrap
    line_active = 1'b0;
    for (int p = 1; p <= 480; p++) begin
      pulse_line_end();
      if (p == 4) chk("t3_v_after4", int'(vpixel), 0);
      if (p == 5) begin
        chk("t3_v_after5", int'(vpixel), 1);
        chk("t3_h_after5", int'(hpixel), 0);
        chk("t3_addr_after5", int'(addr), 128);
      end
      if (p == 475) chk("t3_addr_row95", int'(addr), 12160);
      if (p == 479) chk("t3_done_pre", int'(frame_done), 0);
      if (p == 480) begin
        chk("t3_v_wrap", int'(vpixel), 0);
        chk("t3_done_hi", int'(frame_done), 1);
      end
    end
    step();
    chk("t3_done_lo", int'(frame_done), 0);

    // 4: line_end coincident with terminal sub_cnt, then frame_start beats line_end
    line_active = 1'b1;
    for (int k = 0; k < 119; k++) step();
    chk("t4_h_5", int'(hpixel), 5);
    line_end = 1'b1;
    step();
    line_end = 1'b0;
    chk("t4_h_cleared", int'(hpixel), 0);
    chk("t4_tick_dropped", int'(pixel_tick), 0);
    line_active = 1'b0;
    for (int p = 0; p < 15; p++) pulse_line_end();
    chk("t4_v_3", int'(vpixel), 3);
    line_active = 1'b1;
    frame_start = 1'b1;
    line_end = 1'b1;
    step();
    frame_start = 1'b0;
    line_end = 1'b0;
    line_active = 1'b0;
    chk("t4_fs_v", int'(vpixel), 0);
    chk("t4_fs_h", int'(hpixel), 0);
    chk("t4_fs_done", int'(frame_done), 0);
    for (int p = 0; p < 4; p++) pulse_line_end();
    chk("t4_rep_cleared", int'(vpixel), 0);
    pulse_line_end();
    chk("t4_rep_full", int'(vpixel), 1);

    // 5: asynchronous reset mid-line
    for (int p = 0; p < 45; p++) pulse_line_end();
    line_active = 1'b1;
    for (int k = 0; k < 1280; k++) step();
    chk("t5_h_64", int'(hpixel), 64);
    chk("t5_v_10", int'(vpixel), 10);
    chk("t5_addr", int'(addr), 1344);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_h", int'(hpixel), 0);
    chk("t5_async_v", int'(vpixel), 0);
    chk("t5_async_addr", int'(addr), 0);
    step();
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 19) chk("t5_restart_19", int'(hpixel), 0);
      if (k == 20) chk("t5_restart_20", int'(hpixel), 1);
    end
    line_active = 1'b0;

    // 6: PRESCALE=1, H_PIXELS=4
    chk("t6_idle_h", int'(hpixel_b), 0);
    line_active_b = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_h_%0d", k), int'(hpixel_b), k % 4);
      chk($sformatf("t6_tick_%0d", k), int'(pixel_tick_b), 1);
      chk($sformatf("t6_addr_%0d", k), int'(addr_b), k % 4);
    end
    line_active_b = 1'b0;
    step();
    chk("t6_tick_idle", int'(pixel_tick_b), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
